// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ producers,
// with packet lock capped at MAX_BURST beats. Define FIFO_ARB_SRCID_EN to prepend the source id to fifo_wdata.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 8,
  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
`ifdef FIFO_ARB_SRCID_EN
  localparam int unsigned WDATA_W   = DATA_WIDTH + ID_W
`else
  localparam int unsigned WDATA_W   = DATA_WIDTH
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [WDATA_W-1:0]            fifo_wdata,
  output logic [ID_W-1:0]               grant_id,
  output logic                          grant_vld,
  output logic                          locked
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic                  rr_hit;
  logic [ID_W-1:0]       rr_sel;
  logic                  gnt_locked;
  logic                  gnt_vld;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       gnt_next;
  logic                  gnt_last;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  xfer;

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    rr_hit = 1'b0;
    rr_sel = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!rr_hit && req_valid[ID_W'((32'(rr_ptr_q) + k) % NUM_REQ)]) begin
        rr_hit = 1'b1;
        rr_sel = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign gnt_locked = (state_q == LOCKED);
  assign gnt_id     = gnt_locked ? owner_q : rr_sel;
  assign gnt_vld    = gnt_locked | rr_hit;
  assign gnt_last   = req_last[gnt_id];
  assign gnt_next   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  assign xfer       = gnt_vld & req_valid[gnt_id] & ~fifo_full;

  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Lock on a multi-beat packet; release on last beat or when the burst cap is reached
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (!gnt_last && (MAX_BURST > 1)) begin
            state_d    = LOCKED;
            owner_d    = gnt_id;
            beat_cnt_d = CNT_W'(1);
          end else begin
            rr_ptr_d = gnt_next;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          if (gnt_last || (beat_cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST))) begin
            state_d    = IDLE;
            rr_ptr_d   = gnt_next;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-latency write path; reset forces every output low immediately
  always_comb begin
    grant_vld  = rst_n & gnt_vld;
    grant_id   = rst_n ? gnt_id : '0;
    locked     = rst_n & gnt_locked;
    fifo_wr_en = rst_n & xfer;
    req_ready  = '0;
    if (rst_n && gnt_vld && !fifo_full) req_ready = NUM_REQ'(1) << gnt_id;
`ifdef FIFO_ARB_SRCID_EN
    fifo_wdata = rst_n ? {gnt_id, gnt_data} : '0;
`else
    fifo_wdata = rst_n ? gnt_data : '0;
`endif
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester beat queues feed the DUT and every FIFO
// write is matched against a hand-ordered queue of expected (id, data) writes.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned MB = 4;
  localparam int unsigned IW = 2;
`ifdef FIFO_ARB_SRCID_EN
  localparam int unsigned WW = DW + IW;
`else
  localparam int unsigned WW = DW;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [WW-1:0]    fifo_wdata;
  logic [IW-1:0]    grant_id;
  logic             grant_vld;
  logic             locked;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .grant_vld  (grant_vld),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  logic [DW:0]      beats [NR][64];
  int               head [NR];
  int               tail [NR];
  logic [NR-1:0]    gate;
  logic             full_r;
  logic [IW+DW-1:0] exp_q [$];
  int               n_checks = 0;
  int               n_pass   = 0;
  int               n_writes = 0;

  logic             s_wr_en;
  logic [NR-1:0]    s_ready;
  logic             s_locked;
  logic             s_gvld;
  logic [IW-1:0]    s_gid;
  logic [WW-1:0]    s_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic add_beat(input int id, input logic [DW-1:0] d, input logic last);
    beats[id][tail[id]] = {last, d};
    tail[id]++;
  endtask

  task automatic expect_wr(input int id, input logic [DW-1:0] d);
    exp_q.push_back({IW'(id), d});
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (head[i] != tail[i]) begin
        req_valid[i]          = gate[i];
        req_last[i]           = beats[i][head[i]][DW];
        req_data[i*DW +: DW]  = beats[i][head[i]][DW-1:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
    fifo_full = full_r;
  endtask

  // One clock: drive at negedge, sample/score mid-cycle, retire accepted beats after posedge
  task automatic cycle();
    logic [IW+DW-1:0] e;
    logic [NR-1:0]    acc;
    @(negedge clk);
    drive();
    #1;
    s_wr_en  = fifo_wr_en;
    s_ready  = req_ready;
    s_locked = locked;
    s_gvld   = grant_vld;
    s_gid    = grant_id;
    s_wdata  = fifo_wdata;
    if (fifo_wr_en) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("spurious_wr", 32'(fifo_wr_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_id", 32'(grant_id), 32'(e[IW+DW-1:DW]));
`ifdef FIFO_ARB_SRCID_EN
        check("wr_data", 32'(fifo_wdata), 32'(e));
`else
        check("wr_data", 32'(fifo_wdata), 32'(e[DW-1:0]));
`endif
      end
    end
    acc = req_valid & req_ready;
    @(posedge clk);
    for (int i = 0; i < NR; i++) if (acc[i]) head[i]++;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      cycle();
      c++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive();
    #1;
    check("pre_rst_locked", 32'(locked), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_gvld", 32'(grant_vld), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [4:0] lk_exp;
    rst_n     = 1'b0;
    full_r    = 1'b0;
    gate      = '1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end

    // Round-robin with single-beat packets: 0,1,2,3 repeated, wrapping 3->0
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NR; i++) begin
        add_beat(i, 16'(i*256 + k), 1'b1);
        expect_wr(i, 16'(i*256 + k));
      end
    end
    drive();
    #1;
    check("reset_gvld", 32'(grant_vld), 32'd0);
    check("reset_wr_en", 32'(fifo_wr_en), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_gid", 32'(grant_id), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    n_writes = 0;
    for (int c = 0; c < 12; c++) cycle();
    check("rr_writes", 32'(n_writes), 32'd12);
    check("rr_left", 32'(exp_q.size()), 32'd0);

    // Move rr_ptr to 2, then a 3-beat packet from 2 with 0 and 1 also pending
    add_beat(1, 16'h1F00, 1'b1);
    expect_wr(1, 16'h1F00);
    drain("s2_setup", 5);
    add_beat(2, 16'h2A00, 1'b0);
    add_beat(2, 16'h2A01, 1'b0);
    add_beat(2, 16'h2A02, 1'b1);
    add_beat(0, 16'h0A00, 1'b1);
    add_beat(1, 16'h1A00, 1'b1);
    expect_wr(2, 16'h2A00);
    expect_wr(2, 16'h2A01);
    expect_wr(2, 16'h2A02);
    expect_wr(0, 16'h0A00);
    expect_wr(1, 16'h1A00);
    lk_exp = 5'b00110;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("s2_locked", 32'(s_locked), 32'(lk_exp[c]));
    end
    check("s2_left", 32'(exp_q.size()), 32'd0);

    // Burst cap: 12 beats from 1 without last, 3 from 3 interleave every 4 beats
    add_beat(3, 16'h3A00, 1'b1);
    expect_wr(3, 16'h3A00);
    drain("s3_setup", 5);
    for (int k = 0; k < 12; k++) add_beat(1, 16'(16'h1100 + k), 1'b0);
    for (int k = 0; k < 3; k++) add_beat(3, 16'(16'h3300 + k), 1'b1);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++) expect_wr(1, 16'(16'h1100 + b*4 + k));
      expect_wr(3, 16'(16'h3300 + b));
    end
    n_writes = 0;
    for (int c = 0; c < 15; c++) cycle();
    check("s3_writes", 32'(n_writes), 32'd15);
    check("s3_left", 32'(exp_q.size()), 32'd0);

    // FIFO full for three cycles in the middle of a locked packet
    add_beat(0, 16'h0C00, 1'b0);
    add_beat(0, 16'h0C01, 1'b0);
    add_beat(0, 16'h0C02, 1'b1);
    add_beat(1, 16'h1C00, 1'b1);
    expect_wr(0, 16'h0C00);
    expect_wr(0, 16'h0C01);
    expect_wr(0, 16'h0C02);
    expect_wr(1, 16'h1C00);
    cycle();
    full_r = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("full_wr_en", 32'(s_wr_en), 32'd0);
      check("full_ready", 32'(s_ready), 32'd0);
      check("full_locked", 32'(s_locked), 32'd1);
      check("full_gid", 32'(s_gid), 32'd0);
    end
    full_r = 1'b0;
    drain("s4_drain", 10);

    // Locked owner idles for two cycles while requester 1 waits
    add_beat(3, 16'h3B00, 1'b1);
    expect_wr(3, 16'h3B00);
    drain("s5_setup", 5);
    add_beat(0, 16'h0D00, 1'b0);
    add_beat(0, 16'h0D01, 1'b0);
    add_beat(0, 16'h0D02, 1'b1);
    add_beat(1, 16'h1D00, 1'b1);
    expect_wr(0, 16'h0D00);
    expect_wr(0, 16'h0D01);
    expect_wr(0, 16'h0D02);
    expect_wr(1, 16'h1D00);
    cycle();
    gate[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cycle();
      check("bubble_wr_en", 32'(s_wr_en), 32'd0);
      check("bubble_gid", 32'(s_gid), 32'd0);
      check("bubble_gvld", 32'(s_gvld), 32'd1);
      check("bubble_locked", 32'(s_locked), 32'd1);
      check("bubble_ready", 32'(s_ready), 32'b0001);
    end
    gate[0] = 1'b1;
    drain("s5_drain", 10);

    // Reset while locked; afterwards requester 0 has first priority
    add_beat(2, 16'h2E00, 1'b0);
    add_beat(2, 16'h2E01, 1'b0);
    add_beat(2, 16'h2E02, 1'b1);
    add_beat(0, 16'h0E00, 1'b1);
    expect_wr(2, 16'h2E00);
    expect_wr(0, 16'h0E00);
    expect_wr(2, 16'h2E01);
    expect_wr(2, 16'h2E02);
    cycle();
    pulse_reset();
    drain("s6_drain", 10);

    // Source id in the write data when enabled
    add_beat(3, 16'hBEEF, 1'b1);
    expect_wr(3, 16'hBEEF);
    cycle();
`ifdef FIFO_ARB_SRCID_EN
    check("srcid_wdata", 32'(s_wdata), 32'h3BEEF);
`else
    check("srcid_wdata", 32'(s_wdata), 32'h0BEEF);
`endif
    check("s7_left", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < NR; i++) check("req_q_empty", 32'(head[i]), 32'(tail[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of a synchronous FIFO between NUM_REQ producers.
- Each producer presents valid/ready/last beats; the block forwards one beat per cycle into the FIFO write port.
- Arbitration is round-robin, with packet lock so a multi-beat packet is written contiguously.
- A MAX_BURST cap bounds lock time, preventing starvation.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 16, beat width; equals FIFO data width.
- MAX_BURST, 8, max beats per grant before lock is forcibly released (>=1).
- ID_W, $clog2(NUM_REQ) (min 1), localparam, requester index width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  per-requester last beat of packet
- req_data  in  NUM_REQ*DATA_WIDTH  packed beats; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot accept; beat i transfers when req_valid[i] & req_ready[i]
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_wdata  out  DATA_WIDTH (+ID_W with FIFO_ARB_SRCID_EN)  FIFO write data
- grant_id  out  ID_W  currently selected requester (meaningful when grant_vld)
- grant_vld  out  1  a requester is selected this cycle
- locked  out  1  arbiter in LOCKED state

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - All outputs 0: no grant, no write.
- Data path is combinational from selection:
  - fifo_wr_en = grant_vld & req_valid[grant_id] & !fifo_full.
  - fifo_wdata = req_data of grant_id.
  - req_ready[grant_id] = grant_vld & !fifo_full; all other req_ready bits are 0.
  - Zero-cycle latency from valid to FIFO write.
- IDLE:
  - Selection: first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
  - grant_vld=1 if any valid.
  - On transfer with req_last=0 and MAX_BURST>1: go to LOCKED, owner=selected, beat_cnt=1.
  - On transfer with req_last=1, or when MAX_BURST=1: stay IDLE, rr_ptr=(selected+1) mod NUM_REQ.
  - No transfer (none valid, or fifo_full=1): rr_ptr and state unchanged.
- LOCKED:
  - grant_id=owner, grant_vld=1 regardless of req_valid[owner].
  - Other requesters are never granted; if the owner idles, the block bubbles.
  - Each transfer increments beat_cnt.
  - If the transfer has req_last=1, or beat_cnt+1==MAX_BURST: go to IDLE, rr_ptr=(owner+1) mod NUM_REQ, beat_cnt=0.
- fifo_full=1: no transfer and no state/pointer change; req_data and req_valid must be held by requesters (standard valid/ready).
- beat_cnt width: $clog2(MAX_BURST+1); never exceeds MAX_BURST-1.
- Reset mid-packet: immediate return to IDLE, rr_ptr=0; the partial packet already in the FIFO is not recalled (FIFO is reset by the same rst_n).
- req_last on a non-granted requester is ignored.

Optional Feature:
- FIFO_ARB_SRCID_EN defined:
  - fifo_wdata is DATA_WIDTH+ID_W wide: {grant_id, req_data beat}, id in MSBs.
  - The attached FIFO must be instantiated with matching width.
- Undefined: fifo_wdata is DATA_WIDTH wide, data only.

Test Plan:
- NUM_REQ=4, MAX_BURST=8; all four req_valid=1, req_last=1 every beat, fifo_full=0 -> writes in order 0,1,2,3,0,...; one fifo_wr_en per cycle, rr_ptr wraps 3->0.
- Requester 2 sends 3-beat packet (last on beat 3) while 0 and 1 are also valid, rr_ptr=2 -> beats from 2 written on 3 consecutive cycles, locked=1 for cycles 2-3, then grant moves to 3 if valid, else wraps to 0.
- MAX_BURST=4; requester 1 sends 10 beats with req_last=0 throughout, requester 3 valid -> 4 beats from 1, then 1 beat from 3, then requester 1 regrants.
- fifo_full=1 for 3 cycles in the middle of a locked packet -> fifo_wr_en=0, req_ready=0, beat_cnt and owner unchanged; resumes with the correct next beat when full drops.
- Owner 0 in LOCKED drops req_valid for 2 cycles while 1 is valid -> no writes from 1, grant_id stays 0, locked stays 1.
- rst_n pulsed low during LOCKED -> locked=0, grant_vld=0 and fifo_wr_en=0 asynchronously; after release, requester 0 is first priority.
- With FIFO_ARB_SRCID_EN, requester 3 writes 0xBEEF -> fifo_wdata={2'b11,16'hBEEF}.
